// File: rtl/uart_sender_pkg.sv
// Shared constants for the UART transmitter (and the future receiver):
// FSM encodings, parity modes, frame-bit levels and the bit-period helper.
package uart_sender_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int bit_period(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sender_if.sv
// Send-side bus of the UART transmitter: byte, send strobe, ready flag and serial line.
interface uart_sender_if;

    logic [7:0] TX_DATA;
    logic       TX_EN;
    logic       TX_STATUS;
    logic       UART_TX;

    modport master (output TX_DATA, output TX_EN, input TX_STATUS, input UART_TX);
    modport slave  (input TX_DATA, input TX_EN, output TX_STATUS, output UART_TX);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: pulses bit_done on the last clock of every DIV-clock period.
// A synchronous clear holds it at the start of a period.
module uart_baud_gen #(
    parameter int DIV = 10416
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int         W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    assign bit_done = !clear && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || bit_done) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/uart_sender.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// A request landing on the final edge of a stop bit starts the next frame with no idle gap.
module uart_sender
    import uart_sender_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600,
    parameter int PARITY   = 0
) (
    input  logic clk,
    input  logic reset,
    uart_sender_if.slave bus
);

    localparam int DIV = bit_period(CLK_FREQ, BAUD);

    logic [2:0] state;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       parity_acc;
    logic       tx_q;
    logic       ready_q;
    logic       bit_done;
    logic       baud_clear;
    logic       accept;

    // Holding the counter cleared while idle references bit timing to the accepting edge.
    assign baud_clear = (state == S_IDLE);
    assign accept     = bus.TX_EN && ((state == S_IDLE) || ((state == S_STOP) && bit_done));

    uart_baud_gen #(
        .DIV(DIV)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_acc <= 1'b0;
            tx_q       <= STOP_BIT;
            ready_q    <= 1'b1;
        end else if (accept) begin
            state      <= S_START;
            shift_reg  <= bus.TX_DATA;
            bit_cnt    <= '0;
            parity_acc <= (PARITY == PARITY_ODD);
            tx_q       <= START_BIT;
            ready_q    <= 1'b0;
        end else if (bit_done) begin
            case (state)
                S_START: begin
                    state      <= S_DATA;
                    tx_q       <= shift_reg[0];
                    shift_reg  <= {1'b0, shift_reg[7:1]};
                    parity_acc <= parity_acc ^ shift_reg[0];
                end
                S_DATA: begin
                    if (bit_cnt == 3'd7) begin
                        if (PARITY != PARITY_NONE) begin
                            state <= S_PARITY;
                            tx_q  <= parity_acc;
                        end else begin
                            state <= S_STOP;
                            tx_q  <= STOP_BIT;
                        end
                    end else begin
                        bit_cnt    <= bit_cnt + 3'd1;
                        tx_q       <= shift_reg[0];
                        shift_reg  <= {1'b0, shift_reg[7:1]};
                        parity_acc <= parity_acc ^ shift_reg[0];
                    end
                end
                S_PARITY: begin
                    state <= S_STOP;
                    tx_q  <= STOP_BIT;
                end
                S_STOP: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    tx_q    <= STOP_BIT;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.UART_TX   = tx_q;
    assign bus.TX_STATUS = ready_q;

endmodule

// File: tb/tb_uart_sender.sv
// Bench for uart_sender: three instances (no/even/odd parity) share one stimulus stream;
// a frame-level reference model is compared against every instance on every clock.
module tb_uart_sender;

    localparam int DIV  = 16;
    localparam int MAXN = 400;

    typedef struct {
        logic [7:0] data;
        logic [9:0] seq;
        logic       par_even;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_en = 1'b0;
    logic [7:0] tx_data = 8'h00;

    int total = 0;
    int bad = 0;

    uart_sender_if if0();
    uart_sender_if if1();
    uart_sender_if if2();

    assign if0.TX_EN   = tx_en;
    assign if0.TX_DATA = tx_data;
    assign if1.TX_EN   = tx_en;
    assign if1.TX_DATA = tx_data;
    assign if2.TX_EN   = tx_en;
    assign if2.TX_DATA = tx_data;

    logic [2:0] line_v;
    logic [2:0] stat_v;
    assign line_v = {if2.UART_TX, if1.UART_TX, if0.UART_TX};
    assign stat_v = {if2.TX_STATUS, if1.TX_STATUS, if0.TX_STATUS};

    uart_sender #(.CLK_FREQ(16), .BAUD(1), .PARITY(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    uart_sender #(.CLK_FREQ(16), .BAUD(1), .PARITY(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    uart_sender #(.CLK_FREQ(16), .BAUD(1), .PARITY(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    always #5 clk = ~clk;

    logic cap_tx[3][MAXN];
    logic cap_st[3][MAXN];
    vec_t vecs[10];

    function automatic int frame_len(input int p);
        return (p == 0) ? 10 : 11;
    endfunction

    function automatic logic frame_bit(input int p, input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (p != 0 && k == 9) return (^d) ^ (p == 2);
        return 1'b1;
    endfunction

    task automatic check_bit(input string name, input int p, input int at, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s p=%0d at=%0d got=%b want=%b", name, p, at, got, want);
        end
    endtask

    task automatic check_int(input string name, input int p, input int at, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s p=%0d at=%0d got=%0d want=%0d", name, p, at, got, want);
        end
    endtask

    // Reference model: each frame is a list of bits laid out DIV clocks apart from its accepting edge.
    int         cyc = 0;
    logic       m_active[3];
    int         m_start[3];
    logic [7:0] m_data[3];
    logic       exp_tx[3];
    logic       exp_st[3];

    always @(posedge clk) begin
        cyc++;
        for (int p = 0; p < 3; p++) begin
            if (!reset) begin
                m_active[p] = 1'b0;
            end else begin
                if (m_active[p] && (cyc - m_start[p]) >= frame_len(p) * DIV) m_active[p] = 1'b0;
                if (!m_active[p] && tx_en) begin
                    m_active[p] = 1'b1;
                    m_start[p]  = cyc;
                    m_data[p]   = tx_data;
                end
            end
            if (m_active[p]) begin
                exp_tx[p] = frame_bit(p, m_data[p], (cyc - m_start[p]) / DIV);
                exp_st[p] = 1'b0;
            end else begin
                exp_tx[p] = 1'b1;
                exp_st[p] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int p = 0; p < 3; p++) begin
            check_bit("model_tx", p, cyc, line_v[p], reset ? exp_tx[p] : 1'b1);
            check_bit("model_status", p, cyc, stat_v[p], reset ? exp_st[p] : 1'b1);
        end
    end

    // Inputs for edge c+1 are set at negedge c; cap[c] holds the outputs after edge c.
    task automatic apply_stimulus(input int n, input logic [7:0] d1, input int w1f, input int w1t,
                                  input logic [7:0] d2, input int w2f, input int w2t);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                cap_tx[p][c] = line_v[p];
                cap_st[p][c] = stat_v[p];
            end
            if (c >= w1f && c < w1t) begin
                tx_en = 1'b1;
                tx_data = d1;
            end else if (c >= w2f && c < w2t) begin
                tx_en = 1'b1;
                tx_data = d2;
            end else begin
                tx_en = 1'b0;
                tx_data = 8'($urandom);
            end
        end
    endtask

    task automatic check_frame(input string name, input int p, input int base, input logic [9:0] seq, input logic par);
        logic want;
        for (int k = 0; k < frame_len(p); k++) begin
            if (p == 0 || k < 9) want = seq[k];
            else if (k == 9) want = par ^ (p == 2);
            else want = 1'b1;
            check_bit(name, p, base + k * DIV + DIV / 2, cap_tx[p][base + k * DIV + DIV / 2], want);
        end
    endtask

    function automatic int count_low(input int p, input int from, input int to, input logic use_status);
        int lows = 0;
        for (int c = from; c < to; c++) begin
            if ((use_status ? cap_st[p][c] : cap_tx[p][c]) == 1'b0) lows++;
        end
        return lows;
    endfunction

    initial begin
        vecs[0] = '{8'h55, 10'h2AA, 1'b0};
        vecs[1] = '{8'hA5, 10'h34A, 1'b0};
        vecs[2] = '{8'h00, 10'h200, 1'b0};
        vecs[3] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[4] = '{8'h12, 10'h224, 1'b0};
        vecs[5] = '{8'h81, 10'h302, 1'b0};
        vecs[6] = '{8'h3C, 10'h278, 1'b0};
        vecs[7] = '{8'h01, 10'h202, 1'b1};
        vecs[8] = '{8'h07, 10'h20E, 1'b1};
        vecs[9] = '{8'h80, 10'h300, 1'b1};

        repeat (3) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            check_bit("reset_tx", p, 0, line_v[p], 1'b1);
            check_bit("reset_status", p, 0, stat_v[p], 1'b1);
        end
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(11 * DIV + 4, vecs[i].data, 0, 1, 8'h00, 0, 0);
            for (int p = 0; p < 3; p++) begin
                check_bit("table_idle_before", p, i, cap_st[p][0], 1'b1);
                check_bit("table_latency_tx", p, i, cap_tx[p][1], 1'b0);
                check_bit("table_latency_status", p, i, cap_st[p][1], 1'b0);
                check_frame("table_frame", p, 1, vecs[i].seq, vecs[i].par_even);
                check_int("table_busy", p, i, count_low(p, 0, 11 * DIV + 4, 1'b1), frame_len(p) * DIV);
                check_bit("table_ready_edge", p, i, cap_st[p][1 + frame_len(p) * DIV], 1'b1);
            end
        end

        // Request mid-frame must be dropped.
        apply_stimulus(200, 8'h00, 0, 1, 8'hFF, 50, 51);
        for (int p = 0; p < 3; p++) begin
            check_frame("ignore_frame", p, 1, 10'h200, 1'b0);
            check_int("ignore_busy", p, 0, count_low(p, 0, 200, 1'b1), frame_len(p) * DIV);
        end
        check_bit("ignore_ready_160", 0, 161, cap_st[0][161], 1'b1);

        // Request on the final stop-bit edge chains straight into the next start bit.
        apply_stimulus(340, 8'h3C, 0, 1, 8'hC3, 160, 161);
        check_frame("b2b_first", 0, 1, 10'h278, 1'b0);
        check_frame("b2b_second", 0, 161, 10'h386, 1'b0);
        check_bit("b2b_stop_last", 0, 160, cap_tx[0][160], 1'b1);
        check_bit("b2b_start_at_16", 0, 161, cap_tx[0][161], 1'b0);
        check_bit("b2b_still_busy", 0, 161, cap_st[0][161], 1'b0);
        check_bit("b2b_done", 0, 321, cap_st[0][321], 1'b1);
        check_bit("b2b_par_ignored_st", 1, 177, cap_st[1][177], 1'b1);
        check_int("b2b_par_no_second", 1, 178, count_low(1, 177, 340, 1'b0), 0);

        // Asynchronous reset in the middle of a frame.
        apply_stimulus(70, 8'h81, 0, 1, 8'h00, 0, 0);
        check_bit("reset_mid_busy", 0, 69, cap_st[0][69], 1'b0);
        #2 reset = 1'b0;
        #1;
        for (int p = 0; p < 3; p++) begin
            check_bit("reset_async_tx", p, 70, line_v[p], 1'b1);
            check_bit("reset_async_status", p, 70, stat_v[p], 1'b1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        apply_stimulus(11 * DIV + 4, 8'h81, 0, 1, 8'h00, 0, 0);
        for (int p = 0; p < 3; p++) begin
            check_bit("after_reset_accept", p, 1, cap_tx[p][1], 1'b0);
            check_frame("after_reset_frame", p, 1, 10'h302, 1'b0);
        end

        // Held request: one frame per completion, no re-trigger while busy.
        apply_stimulus(360, 8'h12, 0, 200, 8'h00, 0, 0);
        check_bit("held_first_start", 0, 1, cap_tx[0][1], 1'b0);
        check_bit("held_stop", 0, 160, cap_tx[0][160], 1'b1);
        check_bit("held_second_start", 0, 161, cap_tx[0][161], 1'b0);
        check_frame("held_second_frame", 0, 161, 10'h224, 1'b0);
        check_int("held_busy", 0, 0, count_low(0, 0, 360, 1'b1), 320);
        check_int("held_no_third", 0, 321, count_low(0, 321, 360, 1'b0), 0);

        for (int it = 0; it < 30; it++) begin
            int n;
            int w1f;
            int w2f;
            n   = $urandom_range(360, 180);
            w1f = $urandom_range(3, 0);
            w2f = $urandom_range(n - 25, 100);
            apply_stimulus(n, 8'($urandom), w1f, w1f + $urandom_range(3, 1),
                           8'($urandom), w2f, w2f + $urandom_range(20, 1));
        end
        tx_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_sender.md
UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 Parameter CLK_FREQ, default 100000000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600: serial bit rate in bits/s.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 clk  input  1: single system clock; all state updates on the rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 TX_DATA  input  8: byte to transmit, sampled only on an accepted request.
REQ-007 TX_EN  input  1: one-cycle send request; this is the peripheral's send strobe.
REQ-008 TX_STATUS  output  1: 1 = idle and ready to accept; 0 = frame in progress.
REQ-009 UART_TX  output  1: serial line, idle high, registered.

Function
REQ-010 Bit period DIV = CLK_FREQ/BAUD, integer truncation (100000000/9600 = 10416 clocks).
REQ-011 Frame order: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
- Frame length is 10 bits with no parity and 11 bits with parity.
REQ-012 Parity value: even makes the total count of 1s (data plus parity) even; odd makes it odd.
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE->START on TX_EN=1.
- START->DATA after DIV clocks.
- DATA->PARITY after 8 bit periods when PARITY!=0, otherwise DATA->STOP.
- PARITY->STOP after DIV clocks.
- STOP->IDLE after DIV clocks.
REQ-014 Acceptance: TX_EN=1 in IDLE latches TX_DATA into a shift register.
- On the next edge UART_TX=0 and TX_STATUS=0 (one-cycle latency).
REQ-015 Each bit is held on UART_TX for exactly DIV clocks; the bit counter is 3 bits wide and counts 0..7.
REQ-016 TX_EN while not IDLE is ignored: no queuing, and the in-flight frame and shift register are unaffected.
REQ-017 TX_DATA changes after acceptance have no effect on the frame in progress.
REQ-018 TX_STATUS returns to 1 on the same edge that ends the stop bit.
- Total busy time is 10*DIV clocks with no parity and 11*DIV with parity.
REQ-019 Back-to-back: TX_EN asserted in the first cycle TX_STATUS=1 is accepted.
- The next start bit follows directly after the stop bit, with no extra idle clocks.
REQ-020 The baud counter is cleared on acceptance, so bit timing is referenced to the accepting edge and not to a free-running tick.
REQ-021 TX_EN held high for several cycles in IDLE starts exactly one frame.
- A new frame starts only after the current one completes and TX_EN is still or again high.

Reset
REQ-022 reset=0 forces, asynchronously, regardless of state:
- FSM to IDLE
- UART_TX=1 and TX_STATUS=1
- baud counter, bit counter and shift register to 0
REQ-023 Reset mid-frame aborts the frame; the line returns high immediately and no partial bits are resent after release.
REQ-024 The first TX_EN is accepted on the first rising edge after reset deasserts.

Structure
REQ-025 A shared package holds:
- FSM state encodings
- parity mode constants (NONE=0, EVEN=1, ODD=2)
- the frame-bit constants START_BIT=0 and STOP_BIT=1
REQ-026 One sub-module, uart_baud_gen, provides a DIV-clock bit-period counter.
- It has a synchronous clear input and a one-cycle bit_done pulse.
- It is shared with the future receiver.
REQ-027 The top-level holds the FSM, shift register, bit counter and parity accumulator.

Verification (sim with CLK_FREQ=16, BAUD=1, so DIV=16)
REQ-028 PARITY=0, TX_DATA=0x55, TX_EN pulse.
- UART_TX bit sequence 0,1,0,1,0,1,0,1,0,1, each 16 clocks.
- TX_STATUS low for exactly 160 clocks.
REQ-029 PARITY=1, TX_DATA=0xA5: bits 0,1,0,1,0,0,1,0,1,0(parity),1, busy 176 clocks.
- With PARITY=2 the parity bit is 1.
REQ-030 Send 0x00, then pulse TX_EN with 0xFF at clock 50.
- The 0xFF request is ignored and only the 0x00 frame appears.
- TX_STATUS returns at clock 160.
REQ-031 0x3C then 0xC3, with the second TX_EN in the first TX_STATUS=1 cycle.
- The second start bit begins exactly 16 clocks after the first frame's stop bit began.
REQ-032 Assert reset=0 at clock 70 of a 0x81 frame.
- UART_TX=1 and TX_STATUS=1 asynchronously.
- After release, a new 0x81 frame transmits correctly.
REQ-033 TX_EN held high for 200 clocks with 0x12: exactly two frames start, at clocks 1 and 161.
